fifo_bram_writer: RTL and testbench

//  Drains processed 8-bit pixels from the output FIFO (standard read mode, 1-cycle read latency)
//  and writes them sequentially into the result BRAM, addresses 0..NUM_WORDS-1.

---
 rtl/fifo_bram_writer.sv | 129 ++++++++++++
 tb/tb_fifo_bram_writer.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bram_writer.sv
// fifo_bram_writer
// Drains processed pixels from the output FIFO (standard read mode, one-cycle
// read latency) and writes them sequentially into the result frame BRAM at
// addresses 0..NUM_WORDS-1. One frame per start; DONE holds until re-armed.
module fifo_bram_writer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 13,
    parameter int NUM_WORDS = 4096
) (
    input  logic              clk_100mhz,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_written,
    output logic              underflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] FRAME_LEN = ADDR_W'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic              frame_start;
    logic              rd_en_p0;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] words_cnt;
    logic              rd_vld_p1;
    logic              rd_empty_p1;
    logic              underflow_q;

    // Next-state and read-strobe decode from registered state, counter and the live empty flag.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        rd_en_p0    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_RUN;
                    frame_start = 1'b1;
                end
            end
            ST_RUN: begin
                // Reads stop once a full frame has been requested; later words stay in the FIFO.
                rd_en_p0 = !fifo_empty && (rd_cnt < FRAME_LEN);
                if (rd_vld_p1 && (wr_addr == LAST_ADDR)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt   = ST_RUN;
                    frame_start = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0 -> p1: read-valid pipeline, frame counters and sticky underflow flag.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            rd_cnt      <= '0;
            wr_addr     <= '0;
            words_cnt   <= '0;
            rd_vld_p1   <= 1'b0;
            rd_empty_p1 <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_vld_p1   <= rd_en_p0;
            rd_empty_p1 <= fifo_empty;
            if (frame_start) begin
                rd_cnt    <= '0;
                wr_addr   <= '0;
                words_cnt <= '0;
            end else begin
                if (rd_en_p0) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (rd_vld_p1) begin
                    wr_addr   <= wr_addr + 1'b1;
                    words_cnt <= words_cnt + 1'b1;
                end
            end
            // A returned word whose request was issued against an empty FIFO is garbage.
            if (rd_vld_p1 && rd_empty_p1) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // FIFO data goes straight to the BRAM port in the cycle it is valid.
    assign fifo_rd_en    = rd_en_p0;
    assign bram_en       = rd_vld_p1;
    assign bram_we       = rd_vld_p1;
    assign bram_addr     = wr_addr;
    assign bram_din      = rd_vld_p1 ? fifo_dout : '0;
    assign busy          = (state == ST_RUN);
    assign done          = (state == ST_DONE);
    assign words_written = words_cnt;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_fifo_bram_writer.sv
// Testbench for fifo_bram_writer: a behavioural FIFO feeds the DUT, a monitor
// logs every BRAM write, and each scenario task compares the logged frame with
// the words it pushed into the FIFO.
module tb_fifo_bram_writer;

    localparam int N  = 4096;
    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk_100mhz = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic          hold_empty = 1'b0;
    logic [DW-1:0] fifo_dout  = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          busy;
    logic          done;
    logic [AW-1:0] words_written;
    logic          underflow;

    logic          start1       = 1'b0;
    logic          fifo1_empty  = 1'b0;
    logic [DW-1:0] fifo1_dout   = 8'h5A;
    logic          fifo1_rd_en;
    logic          bram_en1;
    logic          bram_we1;
    logic [AW-1:0] bram_addr1;
    logic [DW-1:0] bram_din1;
    logic          busy1;
    logic          done1;
    logic [AW-1:0] words_written1;
    logic          underflow1;

    always #5 clk_100mhz = ~clk_100mhz;

    fifo_bram_writer #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(N)) u_dut (
        .clk_100mhz   (clk_100mhz),
        .reset        (reset),
        .start        (start),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .busy         (busy),
        .done         (done),
        .words_written(words_written),
        .underflow    (underflow)
    );

    fifo_bram_writer #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(1)) u_dut1 (
        .clk_100mhz   (clk_100mhz),
        .reset        (reset),
        .start        (start1),
        .fifo_dout    (fifo1_dout),
        .fifo_empty   (fifo1_empty),
        .fifo_rd_en   (fifo1_rd_en),
        .bram_en      (bram_en1),
        .bram_we      (bram_we1),
        .bram_addr    (bram_addr1),
        .bram_din     (bram_din1),
        .busy         (busy1),
        .done         (done1),
        .words_written(words_written1),
        .underflow    (underflow1)
    );

    // Behavioural FIFO: storage array with push/pop pointers, registered read data.
    logic [DW-1:0] fmem [0:65535];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

    always @(posedge clk_100mhz) begin
        if (fifo_rd_en) begin
            fifo_dout <= fmem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    // Write log and protocol anomaly counters.
    int            w_addr [$];
    logic [DW-1:0] w_data [$];
    int            w_cyc  [$];
    int            n_rd      = 0;
    int            anomalies = 0;
    int            n_w1      = 0;
    int            n_rd1     = 0;
    int            last_addr1 = -1;
    logic [DW-1:0] last_data1 = '0;
    int            last_cyc1  = 0;

    always @(negedge clk_100mhz) begin
        if (bram_we) begin
            w_addr.push_back(int'(bram_addr));
            w_data.push_back(bram_din);
            w_cyc.push_back(cyc);
            if (int'(bram_addr) >= N) anomalies++;
        end
        if (bram_en !== bram_we) anomalies++;
        if (!bram_we && (bram_din !== '0)) anomalies++;
        if (fifo_rd_en) n_rd++;
        if (bram_we1) begin
            n_w1++;
            last_addr1 = int'(bram_addr1);
            last_data1 = bram_din1;
            last_cyc1  = cyc;
        end
        if (bram_en1 !== bram_we1) anomalies++;
        if (fifo1_rd_en) n_rd1++;
    end

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(negedge clk_100mhz);
        #1;
    endtask

    task automatic push_words(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr] = rnd ? 8'($urandom) : 8'(i);
            wr_ptr++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_writes(input int wb, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (w_addr.size() - wb >= target) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Reference: write k of a frame lands at address k carrying the k-th word
    // popped from the FIFO since the frame was started.
    function automatic int frame_bad(input int wb, input int rb, input int n);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (wb + k >= w_addr.size()) bad++;
            else if (w_addr[wb+k] != k || w_data[wb+k] !== fmem[rb+k]) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({fifo_rd_en, bram_en, bram_we, busy, done, underflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {fifo_rd_en, bram_en, bram_we, busy, done, underflow});
        end
        checks++;
        if (bram_addr !== '0 || bram_din !== '0 || words_written !== '0) begin
            errors++;
            $display("FAIL reset_buses: addr=%0d din=%0d ww=%0d, required 0", bram_addr, bram_din, words_written);
        end
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b busy1=%b done1=%b, required 0", busy, done, busy1, done1);
        end
    endtask

    task automatic test_full_frame();
        int wb, rb, rdb;
        bit ok;
        push_words(N, 1'b0);
        wb = w_addr.size(); rb = rd_ptr; rdb = n_rd;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy: busy=%b, required 1", busy);
        end
        wait_done(6000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_done_timeout: done=%b, required 1", done);
        end
        checks++;
        if (w_addr.size() - wb != N) begin
            errors++;
            $display("FAIL full_count: writes=%0d, required %0d", w_addr.size() - wb, N);
        end
        checks++;
        if (frame_bad(wb, rb, N) != 0) begin
            errors++;
            $display("FAIL full_data: %0d bad writes, required 0", frame_bad(wb, rb, N));
        end
        if (w_cyc.size() > 0) begin
            checks++;
            if (cyc != w_cyc[w_cyc.size()-1] + 1) begin
                errors++;
                $display("FAIL full_done_latency: done at cycle %0d, required %0d", cyc, w_cyc[w_cyc.size()-1] + 1);
            end
        end
        checks++;
        if (words_written !== AW'(N) || busy !== 1'b0 || bram_addr !== AW'(N) || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL full_done_state: ww=%0d busy=%b addr=%0d rd_en=%b, required %0d 0 %0d 0",
                     words_written, busy, bram_addr, fifo_rd_en, N, N);
        end
        checks++;
        if (n_rd - rdb != N || rd_ptr != wr_ptr) begin
            errors++;
            $display("FAIL full_reads: reads=%0d left=%0d, required %0d 0", n_rd - rdb, wr_ptr - rd_ptr, N);
        end
    endtask

    task automatic test_empty_gap();
        int wb, rb, bad;
        bit ok;
        push_words(100, 1'b1);
        wb = w_addr.size(); rb = rd_ptr;
        pulse_start();
        wait_writes(wb, 100, 500, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL gap_reach100: writes=%0d, required 100", w_addr.size() - wb);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fifo_rd_en || bram_we || bram_addr != 100 || words_written != 100 || !busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gap_hold: %0d bad stall cycles (addr=%0d), required 0", bad, bram_addr);
        end
        push_words(N - 100, 1'b1);
        wait_done(6000, ok);
        checks++;
        if (!ok || w_addr.size() - wb != N) begin
            errors++;
            $display("FAIL gap_count: done=%b writes=%0d, required 1 %0d", done, w_addr.size() - wb, N);
        end
        checks++;
        if (frame_bad(wb, rb, N) != 0) begin
            errors++;
            $display("FAIL gap_data: %0d bad writes, required 0", frame_bad(wb, rb, N));
        end
    endtask

    task automatic test_alternate();
        int wb, rb, rdb, adj;
        bit ok;
        push_words(N, 1'b1);
        wb = w_addr.size(); rb = rd_ptr; rdb = n_rd;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
            hold_empty = ~hold_empty;
        end
        hold_empty = 1'b0;
        checks++;
        if (!ok || w_addr.size() - wb != N) begin
            errors++;
            $display("FAIL alt_count: done=%b writes=%0d, required 1 %0d", done, w_addr.size() - wb, N);
        end
        checks++;
        if (frame_bad(wb, rb, N) != 0) begin
            errors++;
            $display("FAIL alt_data: %0d bad writes, required 0", frame_bad(wb, rb, N));
        end
        checks++;
        if (n_rd - rdb != w_addr.size() - wb) begin
            errors++;
            $display("FAIL alt_rd_vs_wr: reads=%0d writes=%0d, required equal", n_rd - rdb, w_addr.size() - wb);
        end
        adj = 0;
        for (int k = wb + 1; k < w_cyc.size(); k++) begin
            if (w_cyc[k] - w_cyc[k-1] < 2) adj++;
        end
        checks++;
        if (adj != 0) begin
            errors++;
            $display("FAIL alt_spacing: %0d back-to-back writes, required 0", adj);
        end
    endtask

    task automatic test_reset_midframe();
        int wb, rb, wb2, rb2;
        bit ok;
        push_words(N, 1'b1);
        wb = w_addr.size(); rb = rd_ptr;
        pulse_start();
        wait_writes(wb, 2000, 3000, ok);
        checks++;
        if (!ok || !fifo_rd_en || !bram_we || !bram_en) begin
            errors++;
            $display("FAIL rst_mid_active: reached=%b rd_en=%b we=%b en=%b, required 1 1 1 1", ok, fifo_rd_en, bram_we, bram_en);
        end
        checks++;
        if (frame_bad(wb, rb, 2000) != 0) begin
            errors++;
            $display("FAIL rst_mid_partial: %0d bad writes, required 0", frame_bad(wb, rb, 2000));
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({fifo_rd_en, bram_en, bram_we, busy, done, underflow, bram_addr, bram_din, words_written} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: rd_en=%b we=%b busy=%b done=%b addr=%0d din=%0d ww=%0d, required all 0",
                     fifo_rd_en, bram_we, busy, done, bram_addr, bram_din, words_written);
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy || done || w_addr.size() - wb != 2000) begin
            errors++;
            $display("FAIL rst_mid_idle: busy=%b done=%b writes=%0d, required 0 0 2000", busy, done, w_addr.size() - wb);
        end
        push_words(N - (wr_ptr - rd_ptr), 1'b1);
        wb2 = w_addr.size(); rb2 = rd_ptr;
        pulse_start();
        wait_done(6000, ok);
        checks++;
        if (!ok || w_addr.size() - wb2 != N) begin
            errors++;
            $display("FAIL rst_mid_refill_count: done=%b writes=%0d, required 1 %0d", done, w_addr.size() - wb2, N);
        end
        checks++;
        if (frame_bad(wb2, rb2, N) != 0) begin
            errors++;
            $display("FAIL rst_mid_refill_data: %0d bad writes, required 0", frame_bad(wb2, rb2, N));
        end
    endtask

    task automatic test_start_held();
        int wb, rb, wb2, rb2;
        bit ok;
        push_words(N + 5, 1'b1);
        wb = w_addr.size(); rb = rd_ptr;
        start = 1'b1;
        wait_done(6000, ok);
        start = 1'b0;
        checks++;
        if (!ok || w_addr.size() - wb != N) begin
            errors++;
            $display("FAIL held_count: done=%b writes=%0d, required 1 %0d", done, w_addr.size() - wb, N);
        end
        checks++;
        if (frame_bad(wb, rb, N) != 0) begin
            errors++;
            $display("FAIL held_data: %0d bad writes, required 0", frame_bad(wb, rb, N));
        end
        repeat (4) tick();
        checks++;
        if (!done || fifo_rd_en || wr_ptr - rd_ptr != 5 || words_written !== AW'(N) || bram_addr !== AW'(N)
            || w_addr.size() - wb != N) begin
            errors++;
            $display("FAIL held_done_hold: done=%b rd_en=%b spare=%0d ww=%0d addr=%0d, required 1 0 5 %0d %0d",
                     done, fifo_rd_en, wr_ptr - rd_ptr, words_written, bram_addr, N, N);
        end
        push_words(N - 5, 1'b1);
        wb2 = w_addr.size(); rb2 = rd_ptr;
        pulse_start();
        wait_done(6000, ok);
        checks++;
        if (!ok || w_addr.size() - wb2 != N) begin
            errors++;
            $display("FAIL rearm_count: done=%b writes=%0d, required 1 %0d", done, w_addr.size() - wb2, N);
        end
        checks++;
        if (frame_bad(wb2, rb2, N) != 0) begin
            errors++;
            $display("FAIL rearm_data: %0d bad writes, required 0", frame_bad(wb2, rb2, N));
        end
    endtask

    task automatic test_single_word();
        bit ok;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || n_w1 != 1 || last_addr1 != 0 || last_data1 !== 8'h5A) begin
            errors++;
            $display("FAIL single_write: done=%b writes=%0d addr=%0d data=%h, required 1 1 0 5a",
                     done1, n_w1, last_addr1, last_data1);
        end
        checks++;
        if (cyc != last_cyc1 + 1 || words_written1 !== AW'(1)) begin
            errors++;
            $display("FAIL single_done: done at %0d ww=%0d, required %0d 1", cyc, words_written1, last_cyc1 + 1);
        end
        repeat (5) tick();
        checks++;
        if (n_w1 != 1 || n_rd1 != 1 || !done1 || fifo1_rd_en) begin
            errors++;
            $display("FAIL single_hold: writes=%0d reads=%0d done=%b rd_en=%b, required 1 1 1 0",
                     n_w1, n_rd1, done1, fifo1_rd_en);
        end
    endtask

    task automatic test_final();
        checks++;
        if (underflow !== 1'b0 || underflow1 !== 1'b0) begin
            errors++;
            $display("FAIL underflow: got %b %b, required 0 0", underflow, underflow1);
        end
        checks++;
        if (anomalies != 0) begin
            errors++;
            $display("FAIL protocol: %0d anomalous cycles, required 0", anomalies);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_empty_gap();
        test_alternate();
        test_reset_midframe();
        test_start_held();
        test_single_word();
        test_final();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
